// File: rtl/hit_gen.sv
// hit_gen: loads a small key table, then flags which of four lanes per beat
//   match a stored key; hit/acc_en are registered, one cycle after acceptance.
// Backpressure: in_ready is high only while streaming (RUN); there is no output stall.
// Ports: clk, rst (async active-low); start/key_valid/key_data/key_last load keys;
//   in_valid/in_data/in_last/in_ready carry 4-lane beats; hit/acc_en feed the
//   accumulator; busy is high outside IDLE; done pulses once per stream.
// Optional macro HIT_GEN_DEDUP_EN: each key hits at most once per stream
//   (lowest lane wins within a beat).
module hit_gen #(
  parameter int KEY_W = 8,
  parameter int NKEY  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_data,
  input  logic               key_last,
  input  logic               in_valid,
  input  logic [4*KEY_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [3:0]         hit,
  output logic               acc_en,
  output logic               busy,
  output logic               done
);

  localparam int IW = $clog2(NKEY);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [KEY_W-1:0] key_mem [NKEY];
  logic [NKEY-1:0]  key_vld;
  logic [CW-1:0]    key_count;
  logic [IW-1:0]    key_slot;
  logic             key_wr;
  logic             load_end;
  logic             accept;
  logic [3:0]       hit_nxt;
`ifdef HIT_GEN_DEDUP_EN
  logic [NKEY-1:0]  key_used;
  logic [NKEY-1:0]  claim;
`endif

  assign key_slot = key_count[IW-1:0];
  assign key_wr   = (state == S_LOAD) && key_valid && (key_count < CW'(NKEY));
  // Load ends on an explicit last key or when the table fills; a full table
  // in LOAD (nothing can be stored) also leaves so the stream cannot stall.
  assign load_end = (key_wr && (key_last || (key_count == CW'(NKEY - 1)))) ||
                    ((state == S_LOAD) && (key_count == CW'(NKEY)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_end) state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane/key compare. With dedup, lanes are walked low to high and each lane
  // claims every fresh key it matches, so higher lanes cannot reuse them.
  always_comb begin
    hit_nxt = 4'b0;
`ifdef HIT_GEN_DEDUP_EN
    claim = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NKEY; k++) begin
        if (key_vld[k] && (key_mem[k] == in_data[i*KEY_W +: KEY_W])) begin
`ifdef HIT_GEN_DEDUP_EN
          if (!key_used[k] && !claim[k]) begin
            hit_nxt[i] = 1'b1;
            claim[k]   = 1'b1;
          end
`else
          hit_nxt[i] = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      key_count <= '0;
      key_vld   <= '0;
      hit       <= 4'b0;
      acc_en    <= 1'b0;
`ifdef HIT_GEN_DEDUP_EN
      key_used  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      acc_en <= accept;
      hit    <= accept ? hit_nxt : 4'b0;
      if ((state == S_IDLE) && start) begin
        key_count <= '0;
        key_vld   <= '0;
`ifdef HIT_GEN_DEDUP_EN
        key_used  <= '0;
`endif
      end
      if (key_wr) begin
        key_vld[key_slot] <= 1'b1;
        key_count         <= key_count + 1'b1;
      end
`ifdef HIT_GEN_DEDUP_EN
      if (accept) key_used <= key_used | claim;
`endif
    end
  end

  // Key storage needs no reset: the valid bits gate every compare.
  always_ff @(posedge clk) begin
    if (key_wr) key_mem[key_slot] <= key_data;
  end

endmodule
